// File: rtl/csc_pkg.sv
// Shared definitions for the RGB -> YCrCb stream converter: mode encoding,
// coefficient derivation for BT.601 / BT.709 at any fractional width, and
// the output saturation helper.
package csc_pkg;

   typedef enum logic {
      CSC_BT601 = 1'b0,
      CSC_BT709 = 1'b1
   } csc_mode_e;

   // Luma weights of each standard as exact decimal fractions (num / den)
   localparam longint BT601_KR_NUM = 299;
   localparam longint BT601_KB_NUM = 114;
   localparam longint BT601_DEN    = 1000;
   localparam longint BT709_KR_NUM = 2126;
   localparam longint BT709_KB_NUM = 722;
   localparam longint BT709_DEN    = 10000;

   typedef struct packed {
      int kr;
      int kg;
      int kb;
      int scr;
      int scb;
   } csc_coef_t;

   // Integer division rounded to nearest (ties up) for positive operands
   function automatic longint csc_round_div(longint num, longint den);
      return (2 * num + den) / (2 * den);
   endfunction

   // Kg is taken as the remainder so the three luma weights always sum to one;
   // chroma scales are 1 / (2 * (1 - K)) in Q1.coef_w
   function automatic csc_coef_t csc_coefs(csc_mode_e mode, int coef_w);
      csc_coef_t c;
      longint    one;
      longint    kr_num;
      longint    kb_num;
      longint    den;
      one = longint'(1) << coef_w;
      if (mode == CSC_BT709) begin
         kr_num = BT709_KR_NUM;
         kb_num = BT709_KB_NUM;
         den    = BT709_DEN;
      end else begin
         kr_num = BT601_KR_NUM;
         kb_num = BT601_KB_NUM;
         den    = BT601_DEN;
      end
      c.kr  = int'(csc_round_div(kr_num * one, den));
      c.kb  = int'(csc_round_div(kb_num * one, den));
      c.kg  = int'(one) - c.kr - c.kb;
      c.scr = int'(csc_round_div(one * den, 2 * (den - kr_num)));
      c.scb = int'(csc_round_div(one * den, 2 * (den - kb_num)));
      return c;
   endfunction

   // Saturate a signed value into the unsigned range [0, 2^data_w - 1]
   function automatic longint csc_clamp(longint v, int data_w);
      longint max_v;
      longint res;
      max_v = (longint'(1) << data_w) - 1;
      if (v < 0) begin
         res = 0;
      end else if (v > max_v) begin
         res = max_v;
      end else begin
         res = v;
      end
      return res;
   endfunction

endpackage

// File: rtl/ycrcb_stream_converter_if.sv
// Pixel stream bundle for the colour converter: RGB input side with frame
// sideband and standard select, YCrCb output side, valid/ready on both.
interface ycrcb_stream_converter_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_r;
   logic [DATA_W-1:0] in_g;
   logic [DATA_W-1:0] in_b;
   logic              in_sof;
   logic              in_eol;
   logic              mode;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_y;
   logic [DATA_W-1:0] out_cr;
   logic [DATA_W-1:0] out_cb;
   logic              out_sof;
   logic              out_eol;

   // Pixel source and result sink
   modport master (
      output in_valid, in_r, in_g, in_b, in_sof, in_eol, mode, out_ready,
      input  in_ready, out_valid, out_y, out_cr, out_cb, out_sof, out_eol
   );

   // The converter itself
   modport slave (
      input  in_valid, in_r, in_g, in_b, in_sof, in_eol, mode, out_ready,
      output in_ready, out_valid, out_y, out_cr, out_cb, out_sof, out_eol
   );
endinterface

// File: rtl/csc_coef_sel.sv
// Maps a colour standard to its luma weights and chroma scales. Both sets
// are elaboration-time constants derived from COEF_W.
module csc_coef_sel
   import csc_pkg::*;
#(
   parameter int COEF_W = 10
) (
   input  csc_mode_e     mode,
   output logic [COEF_W:0] kr,
   output logic [COEF_W:0] kg,
   output logic [COEF_W:0] kb,
   output logic [COEF_W:0] scr,
   output logic [COEF_W:0] scb
);
   localparam csc_coef_t C601 = csc_coefs(CSC_BT601, COEF_W);
   localparam csc_coef_t C709 = csc_coefs(CSC_BT709, COEF_W);

   // Select the coefficient set of the requested standard
   always_comb begin
      kr  = (COEF_W+1)'(C601.kr);
      kg  = (COEF_W+1)'(C601.kg);
      kb  = (COEF_W+1)'(C601.kb);
      scr = (COEF_W+1)'(C601.scr);
      scb = (COEF_W+1)'(C601.scb);
      if (mode == CSC_BT709) begin
         kr  = (COEF_W+1)'(C709.kr);
         kg  = (COEF_W+1)'(C709.kg);
         kb  = (COEF_W+1)'(C709.kb);
         scr = (COEF_W+1)'(C709.scr);
         scb = (COEF_W+1)'(C709.scb);
      end
   end
endmodule

// File: rtl/ycrcb_stream_converter.sv
// Streaming RGB -> YCrCb converter, three register stages, global stall on
// output back-pressure. The colour standard is latched per frame and each
// pixel carries its own chroma scales through the pipe.
// Build option: define CSC_ROUND_EN to round half up before each final
// shift; otherwise results are floor-truncated.
module ycrcb_stream_converter
   import csc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COEF_W = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   ycrcb_stream_converter_if.slave  bus
);
   localparam int K_W     = COEF_W + 1;
   localparam int PROD_W  = DATA_W + COEF_W + 1;
   localparam int SUM_W   = DATA_W + COEF_W + 2;
   localparam int CHR_W   = SUM_W + COEF_W + 2;
   localparam int Y_SHIFT = COEF_W;
   localparam int C_SHIFT = 2 * COEF_W;
`ifdef CSC_ROUND_EN
   localparam longint Y_RND = longint'(1) << (Y_SHIFT - 1);
   localparam longint C_RND = longint'(1) << (C_SHIFT - 1);
`else
   localparam longint Y_RND = 0;
   localparam longint C_RND = 0;
`endif
   localparam longint C_OFS = longint'(1) << (DATA_W - 1 + C_SHIFT);

   logic                     adv;
   logic                     accept;
   csc_mode_e                active_mode;
   csc_mode_e                pix_mode;
   logic [K_W-1:0]           kr;
   logic [K_W-1:0]           kg;
   logic [K_W-1:0]           kb;
   logic [K_W-1:0]           scr;
   logic [K_W-1:0]           scb;

   logic                     s1_valid;
   logic                     s1_sof;
   logic                     s1_eol;
   logic [PROD_W-1:0]        s1_pr;
   logic [PROD_W-1:0]        s1_pg;
   logic [PROD_W-1:0]        s1_pb;
   logic [DATA_W-1:0]        s1_r;
   logic [DATA_W-1:0]        s1_b;
   logic [K_W-1:0]           s1_scr;
   logic [K_W-1:0]           s1_scb;
   logic [SUM_W-1:0]         s1_yfull;
   logic signed [SUM_W-1:0]  s1_dr;
   logic signed [SUM_W-1:0]  s1_db;

   logic                     s2_valid;
   logic                     s2_sof;
   logic                     s2_eol;
   logic [SUM_W-1:0]         s2_yfull;
   logic signed [SUM_W-1:0]  s2_dr;
   logic signed [SUM_W-1:0]  s2_db;
   logic [K_W-1:0]           s2_scr;
   logic [K_W-1:0]           s2_scb;
   logic signed [CHR_W-1:0]  cr_prod;
   logic signed [CHR_W-1:0]  cb_prod;
   longint                   y_val;
   longint                   cr_val;
   longint                   cb_val;

   logic                     out_valid_q;
   logic                     out_sof_q;
   logic                     out_eol_q;
   logic [DATA_W-1:0]        out_y_q;
   logic [DATA_W-1:0]        out_cr_q;
   logic [DATA_W-1:0]        out_cb_q;

   assign adv          = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && adv;
   assign bus.in_ready = adv;
   assign pix_mode     = bus.in_sof ? csc_mode_e'(bus.mode) : active_mode;

   csc_coef_sel #(.COEF_W(COEF_W)) u_coef_sel (
      .mode (pix_mode),
      .kr   (kr),
      .kg   (kg),
      .kb   (kb),
      .scr  (scr),
      .scb  (scb)
   );

   // Latch the requested standard on every accepted start-of-frame pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         active_mode <= CSC_BT601;
      end else if (accept && bus.in_sof) begin
         active_mode <= csc_mode_e'(bus.mode);
      end
   end

   // Stage 1: weighted components, raw R/B and this pixel's chroma scales
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (adv) begin
         s1_valid <= bus.in_valid;
         s1_sof   <= bus.in_sof;
         s1_eol   <= bus.in_eol;
         s1_pr    <= PROD_W'(kr) * PROD_W'(bus.in_r);
         s1_pg    <= PROD_W'(kg) * PROD_W'(bus.in_g);
         s1_pb    <= PROD_W'(kb) * PROD_W'(bus.in_b);
         s1_r     <= bus.in_r;
         s1_b     <= bus.in_b;
         s1_scr   <= scr;
         s1_scb   <= scb;
      end
   end

   // Full-precision luma and colour differences, all in Q.COEF_W
   always_comb begin
      s1_yfull = SUM_W'(s1_pr) + SUM_W'(s1_pg) + SUM_W'(s1_pb);
      s1_dr    = $signed(SUM_W'(s1_r) << COEF_W) - $signed(s1_yfull);
      s1_db    = $signed(SUM_W'(s1_b) << COEF_W) - $signed(s1_yfull);
   end

   // Stage 2: register luma sum and signed R-Y / B-Y
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_sof   <= s1_sof;
         s2_eol   <= s1_eol;
         s2_yfull <= s1_yfull;
         s2_dr    <= s1_dr;
         s2_db    <= s1_db;
         s2_scr   <= s1_scr;
         s2_scb   <= s1_scb;
      end
   end

   // Chroma scaling, mid-scale offset and floor shift before saturation
   always_comb begin
      cr_prod = CHR_W'(s2_dr) * CHR_W'($signed({1'b0, s2_scr}));
      cb_prod = CHR_W'(s2_db) * CHR_W'($signed({1'b0, s2_scb}));
      y_val   = (longint'(s2_yfull) + Y_RND) >>> Y_SHIFT;
      cr_val  = (longint'(cr_prod) + C_OFS + C_RND) >>> C_SHIFT;
      cb_val  = (longint'(cb_prod) + C_OFS + C_RND) >>> C_SHIFT;
   end

   // Stage 3: saturated results and sideband presented downstream
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
         out_y_q     <= '0;
         out_cr_q    <= '0;
         out_cb_q    <= '0;
      end else if (adv) begin
         out_valid_q <= s2_valid;
         out_sof_q   <= s2_sof;
         out_eol_q   <= s2_eol;
         out_y_q     <= DATA_W'(csc_clamp(y_val, DATA_W));
         out_cr_q    <= DATA_W'(csc_clamp(cr_val, DATA_W));
         out_cb_q    <= DATA_W'(csc_clamp(cb_val, DATA_W));
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sof   = out_sof_q;
   assign bus.out_eol   = out_eol_q;
   assign bus.out_y     = out_y_q;
   assign bus.out_cr    = out_cr_q;
   assign bus.out_cb    = out_cb_q;
endmodule

// File: tb/tb_ycrcb_stream_converter.sv
// Self-checking bench for ycrcb_stream_converter (DATA_W=8, COEF_W=10).
// Expected pixels come from an arithmetic reference of the colour equations
// held in a scoreboard queue; directed steps check known colours, latency,
// back-pressure, per-frame mode switching and reset flush.
`timescale 1ns/1ps
module tb_ycrcb_stream_converter;
   localparam int DATA_W = 8;
   localparam int COEF_W = 10;

   typedef struct {
      int y;
      int cr;
      int cb;
      int sof;
      int eol;
      int acc_cycle;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ycrcb_stream_converter_if #(.DATA_W(DATA_W)) bus ();

   ycrcb_stream_converter #(.DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   model_mode = 0;
   int   out_count = 0;
   int   last_y = -1;
   int   last_cr = -1;
   int   last_cb = -1;
   int   last_lat = -1;

   function automatic longint floorDiv(longint a, longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int sat8(longint v);
      if (v < 0) return 0;
      if (v > 255) return 255;
      return int'(v);
   endfunction

   // Colour equations written directly from the standard's definitions
   function automatic exp_t refPixel(int r, int g, int b, int m, int sof, int eol);
      exp_t   e;
      longint kr, kg, kb, scr, scb, yfull, rnd_y, rnd_c;
      if (m != 0) begin
         kr = 218; kg = 732; kb = 74;  scr = 650; scb = 552;
      end else begin
         kr = 306; kg = 601; kb = 117; scr = 730; scb = 578;
      end
      rnd_y = 0;
      rnd_c = 0;
`ifdef CSC_ROUND_EN
      rnd_y = 512;
      rnd_c = 524288;
`endif
      yfull = kr * r + kg * g + kb * b;
      e.y   = sat8(floorDiv(yfull + rnd_y, 1024));
      e.cr  = sat8(floorDiv((longint'(r) * 1024 - yfull) * scr + rnd_c, 1048576) + 128);
      e.cb  = sat8(floorDiv((longint'(b) * 1024 - yfull) * scb + rnd_c, 1048576) + 128);
      e.sof = sof;
      e.eol = eol;
      e.acc_cycle = 0;
      return e;
   endfunction

   task automatic checkValue(input string tag, input longint obs, input longint expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Compare a transferred output pixel with the oldest expected pixel
   task automatic checkOutput();
      exp_t e;
      checkValue("sb_has_pixel", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkValue("out_y", bus.out_y, e.y);
         checkValue("out_cr", bus.out_cr, e.cr);
         checkValue("out_cb", bus.out_cb, e.cb);
         checkValue("out_sof", bus.out_sof, e.sof);
         checkValue("out_eol", bus.out_eol, e.eol);
         last_y   = int'(bus.out_y);
         last_cr  = int'(bus.out_cr);
         last_cb  = int'(bus.out_cb);
         last_lat = cycle - e.acc_cycle;
      end
      out_count++;
   endtask

   // Drive one cycle of stimulus, then log transfers seen before the next edge
   task automatic applyStimulus(input int v, input int r, input int g, input int b,
                                input int sof, input int eol, input int md,
                                input int ordy, output int acc);
      exp_t e;
      @(negedge clk);
      bus.in_valid  = (v != 0);
      bus.in_r      = DATA_W'(r);
      bus.in_g      = DATA_W'(g);
      bus.in_b      = DATA_W'(b);
      bus.in_sof    = (sof != 0);
      bus.in_eol    = (eol != 0);
      bus.mode      = (md != 0);
      bus.out_ready = (ordy != 0);
      #1;
      cycle++;
      acc = (bus.in_valid && bus.in_ready) ? 1 : 0;
      if (bus.out_valid && bus.out_ready) checkOutput();
      if (acc != 0) begin
         if (sof != 0) model_mode = md;
         e = refPixel(r, g, b, model_mode, sof, eol);
         e.acc_cycle = cycle;
         sb.push_back(e);
      end
   endtask

   task automatic idleCycles(input int n, input int ordy);
      int acc;
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, ordy, acc);
   endtask

   initial begin
      int acc;
      int i;
      int guard;
      int stall_cnt;
      int base;
      int sent;
      int pr[20];
      int pg[20];
      int pb[20];

      bus.in_valid = 1'b0; bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;
      bus.in_sof = 1'b0; bus.in_eol = 1'b0; bus.mode = 1'b0; bus.out_ready = 1'b0;

      $display("[TB] reset state");
      rst = 1'b1;
      idleCycles(2, 0);
      checkValue("rst_out_valid", bus.out_valid, 0);
      checkValue("rst_out_y", bus.out_y, 0);
      checkValue("rst_out_cr", bus.out_cr, 0);
      checkValue("rst_out_cb", bus.out_cb, 0);
      checkValue("rst_out_sof", bus.out_sof, 0);
      checkValue("rst_out_eol", bus.out_eol, 0);
      checkValue("rst_in_ready", bus.in_ready, 1);
      rst = 1'b0;

      $display("[TB] white pixel and latency");
      applyStimulus(1, 255, 255, 255, 1, 1, 0, 1, acc);
      checkValue("white_accept", acc, 1);
      idleCycles(5, 1);
      checkValue("white_y", last_y, 255);
      checkValue("white_cr", last_cr, 128);
      checkValue("white_cb", last_cb, 128);
      checkValue("white_latency", last_lat, 3);

      $display("[TB] black and pure red");
      applyStimulus(1, 0, 0, 0, 1, 1, 0, 1, acc);
      idleCycles(5, 1);
      checkValue("black_y", last_y, 0);
      checkValue("black_cr", last_cr, 128);
      checkValue("black_cb", last_cb, 128);
      applyStimulus(1, 255, 0, 0, 1, 1, 0, 1, acc);
      idleCycles(5, 1);
      checkValue("red601_y", last_y, 76);
      checkValue("red601_cr", last_cr, 255);
`ifdef CSC_ROUND_EN
      checkValue("red601_cb", last_cb, 85);
`else
      checkValue("red601_cb", last_cb, 84);
`endif

      $display("[TB] back-pressure burst");
      for (int k = 0; k < 20; k++) begin
         pr[k] = int'($urandom_range(255));
         pg[k] = int'($urandom_range(255));
         pb[k] = int'($urandom_range(255));
      end
      base = out_count;
      stall_cnt = 0;
      i = 0;
      guard = 0;
      while (i < 20 && guard < 200) begin
         applyStimulus(1, pr[i], pg[i], pb[i], (i == 0) ? 1 : 0, (i == 19) ? 1 : 0, 0,
                       (guard >= 8 && guard < 13) ? 0 : 1, acc);
         if (!bus.in_ready) stall_cnt++;
         if (acc != 0) i++;
         guard++;
      end
      checkValue("bp_sent", i, 20);
      idleCycles(10, 1);
      checkValue("bp_stall_cycles", stall_cnt, 5);
      checkValue("bp_outputs", out_count - base, 20);

      $display("[TB] mode switch at frame boundary");
      applyStimulus(1, 255, 0, 0, 1, 0, 0, 1, acc);
      applyStimulus(1, 255, 0, 0, 0, 0, 1, 1, acc);
      applyStimulus(1, 255, 0, 0, 0, 1, 1, 1, acc);
      idleCycles(6, 1);
      checkValue("frameA_last_y", last_y, 76);
      applyStimulus(1, 255, 0, 0, 1, 0, 1, 1, acc);
      applyStimulus(1, 255, 0, 0, 0, 0, 0, 1, acc);
      applyStimulus(1, 255, 0, 0, 0, 1, 0, 1, acc);
      idleCycles(6, 1);
      checkValue("frameB_red709_y", last_y, 54);

      $display("[TB] reset with pixels in flight");
      base = out_count;
      applyStimulus(1, 10, 20, 30, 1, 0, 0, 1, acc);
      applyStimulus(1, 40, 50, 60, 0, 0, 0, 1, acc);
      applyStimulus(1, 70, 80, 90, 0, 1, 0, 1, acc);
      idleCycles(1, 0);
      checkValue("flush_pre_valid", bus.out_valid, 1);
      rst = 1'b1;
      idleCycles(1, 0);
      checkValue("flush_out_valid", bus.out_valid, 0);
      sb.delete();
      model_mode = 0;
      rst = 1'b0;
      idleCycles(1, 1);
      checkValue("flush_in_ready", bus.in_ready, 1);
      idleCycles(10, 1);
      checkValue("flush_no_output", out_count - base, 0);

      $display("[TB] random traffic");
      sent = 0;
      guard = 0;
      while (sent < 10000 && guard < 60000) begin
         applyStimulus(($urandom_range(99) < 70) ? 1 : 0,
                       int'($urandom_range(255)), int'($urandom_range(255)),
                       int'($urandom_range(255)),
                       ($urandom_range(19) == 0) ? 1 : 0,
                       ($urandom_range(9) == 0) ? 1 : 0,
                       int'($urandom_range(1)),
                       ($urandom_range(99) < 70) ? 1 : 0, acc);
         if (acc != 0) sent++;
         guard++;
      end
      checkValue("rand_sent", sent, 10000);
      guard = 0;
      while (sb.size() > 0 && guard < 100) begin
         idleCycles(1, 1);
         guard++;
      end
      checkValue("rand_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
